// File: rtl/bp_be_stride_pf_sched.sv
// Stride prefetch scheduler: tracks confirmed-stride streams from the RPT and issues
// round-robin prefetches to the D$ prefetch port. Optional macro: BP_BE_PF_PAGE_BOUND_EN.
module bp_be_stride_pf_sched #(
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int streams_p      = 4,
    parameter int degree_p       = 4,
    parameter int pc_tag_width_p = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      train_v_i,
    input  logic [vaddr_width_p-1:0]  train_pc_i,
    input  logic [vaddr_width_p-1:0]  train_addr_i,
    input  logic [stride_width_p-1:0] train_stride_i,
    input  logic                      flush_i,
    input  logic                      demand_v_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_i,
    output logic                      busy_o
);

    localparam int                  idx_w_lp   = $clog2(streams_p);
    localparam logic [3:0]          degree_lp  = 4'(degree_p);
    localparam logic [idx_w_lp-1:0] one_idx_lp = idx_w_lp'(1);
    localparam logic [idx_w_lp-1:0] zero_idx_lp = idx_w_lp'(0);

    // Returns {found, index} of the first set bit of vec at or after start, wrapping.
    function automatic logic [idx_w_lp:0] first_set(input logic [streams_p-1:0] vec,
                                                    input logic [idx_w_lp-1:0]  start);
        logic                found;
        logic [idx_w_lp-1:0] idx;
        logic [idx_w_lp-1:0] pick;
        found = 1'b0;
        pick  = start;
        for (int k = 0; k < streams_p; k++) begin
            idx = start + idx_w_lp'(k);
            if (!found && vec[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    logic [streams_p-1:0]      v_r, v_n_s, v_fin_s;
    logic [pc_tag_width_p-1:0] tag_r    [streams_p];
    logic [pc_tag_width_p-1:0] tag_n_s  [streams_p];
    logic [vaddr_width_p-1:0]  addr_r   [streams_p];
    logic [vaddr_width_p-1:0]  addr_n_s [streams_p];
    logic [vaddr_width_p-1:0]  stride_r [streams_p];
    logic [vaddr_width_p-1:0]  stride_n_s [streams_p];
    logic [3:0]                rem_r    [streams_p];
    logic [3:0]                rem_n_s  [streams_p];
`ifdef BP_BE_PF_PAGE_BOUND_EN
    logic [vaddr_width_p-13:0] page_r   [streams_p];
    logic [vaddr_width_p-13:0] page_n_s [streams_p];
`endif

    logic [idx_w_lp-1:0]      rr_r, rr_n_s, victim_r, victim_n_s;
    logic                     pf_v_r, pf_v_n_s;
    logic [vaddr_width_p-1:0] pf_addr_r, pf_addr_n_s;
    logic                     busy_r, busy_n_s;

    logic [pc_tag_width_p-1:0] train_tag_s;
    logic [vaddr_width_p-1:0]  train_stride_ext_s;
    logic [streams_p-1:0]      hit_vec_s;
    logic [idx_w_lp:0]         hit_sel_s, inv_sel_s, win_sel_s;
    logic [idx_w_lp-1:0]       win_idx_s, train_idx_s;
    logic                      train_fire_s, alloc_full_s;
    logic                      slot_free_s, launch_try_s, page_cross_s, launch_s, kill_s;
    logic                      unused_pc_s;

    assign train_tag_s        = train_pc_i[pc_tag_width_p-1:0];
    assign unused_pc_s        = ^train_pc_i[vaddr_width_p-1:pc_tag_width_p];
    assign train_stride_ext_s = {{(vaddr_width_p-stride_width_p){train_stride_i[stride_width_p-1]}},
                                 train_stride_i};

    // Tag comparison against every valid entry.
    always_comb begin
        for (int i = 0; i < streams_p; i++) begin
            hit_vec_s[i] = v_r[i] & (tag_r[i] == train_tag_s);
        end
    end

    assign hit_sel_s    = first_set(hit_vec_s, zero_idx_lp);
    assign inv_sel_s    = first_set(~v_r, zero_idx_lp);
    assign win_sel_s    = first_set(v_r, rr_r);
    assign win_idx_s    = win_sel_s[idx_w_lp-1:0];

    assign train_fire_s = train_v_i & (train_stride_i != '0) & ~flush_i;
    assign alloc_full_s = ~hit_sel_s[idx_w_lp] & ~inv_sel_s[idx_w_lp];
    assign train_idx_s  = hit_sel_s[idx_w_lp] ? hit_sel_s[idx_w_lp-1:0] :
                          inv_sel_s[idx_w_lp] ? inv_sel_s[idx_w_lp-1:0] : victim_r;

    assign slot_free_s  = ~pf_v_r | pf_ready_i;
    assign launch_try_s = slot_free_s & ~demand_v_i & ~flush_i & win_sel_s[idx_w_lp];

`ifdef BP_BE_PF_PAGE_BOUND_EN
    assign page_cross_s = (addr_r[win_idx_s][vaddr_width_p-1:12] != page_r[win_idx_s]);
`else
    assign page_cross_s = 1'b0;
`endif

    // A page-crossing winner is retired without issuing anything.
    assign launch_s = launch_try_s & ~page_cross_s;
    assign kill_s   = launch_try_s & page_cross_s;

    // Stream table next state: launch update first, training write overrides it.
    always_comb begin
        v_n_s = v_r;
        for (int i = 0; i < streams_p; i++) begin
            tag_n_s[i]    = tag_r[i];
            addr_n_s[i]   = addr_r[i];
            stride_n_s[i] = stride_r[i];
            rem_n_s[i]    = rem_r[i];
`ifdef BP_BE_PF_PAGE_BOUND_EN
            page_n_s[i]   = page_r[i];
`endif
        end
        rr_n_s     = rr_r;
        victim_n_s = victim_r;

        if (launch_s) begin
            addr_n_s[win_idx_s] = addr_r[win_idx_s] + stride_r[win_idx_s];
            rem_n_s[win_idx_s]  = rem_r[win_idx_s] - 4'd1;
            v_n_s[win_idx_s]    = (rem_r[win_idx_s] != 4'd1);
            rr_n_s              = win_idx_s + one_idx_lp;
        end else if (kill_s) begin
            v_n_s[win_idx_s]    = 1'b0;
            rr_n_s              = win_idx_s + one_idx_lp;
        end else begin
            rr_n_s              = rr_r;
        end

        if (train_fire_s) begin
            v_n_s[train_idx_s]      = 1'b1;
            tag_n_s[train_idx_s]    = train_tag_s;
            addr_n_s[train_idx_s]   = train_addr_i + train_stride_ext_s;
            stride_n_s[train_idx_s] = train_stride_ext_s;
            rem_n_s[train_idx_s]    = degree_lp;
`ifdef BP_BE_PF_PAGE_BOUND_EN
            page_n_s[train_idx_s]   = train_addr_i[vaddr_width_p-1:12];
`endif
            victim_n_s = alloc_full_s ? (victim_r + one_idx_lp) : victim_r;
        end else begin
            victim_n_s = victim_r;
        end

        v_fin_s = flush_i ? '0 : v_n_s;
    end

    // Issue slot next state; a pending request only leaves by handshake or flush.
    always_comb begin
        pf_v_n_s    = pf_v_r;
        pf_addr_n_s = pf_addr_r;
        if (flush_i) begin
            pf_v_n_s    = 1'b0;
        end else if (launch_s) begin
            pf_v_n_s    = 1'b1;
            pf_addr_n_s = addr_r[win_idx_s];
        end else if (pf_v_r & pf_ready_i) begin
            pf_v_n_s    = 1'b0;
        end else begin
            pf_v_n_s    = pf_v_r;
        end
        busy_n_s = (|v_fin_s) | pf_v_n_s;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r       <= '0;
            rr_r      <= '0;
            victim_r  <= '0;
            pf_v_r    <= 1'b0;
            pf_addr_r <= '0;
            busy_r    <= 1'b0;
            for (int i = 0; i < streams_p; i++) begin
                tag_r[i]    <= '0;
                addr_r[i]   <= '0;
                stride_r[i] <= '0;
                rem_r[i]    <= 4'd0;
`ifdef BP_BE_PF_PAGE_BOUND_EN
                page_r[i]   <= '0;
`endif
            end
        end else begin
            v_r       <= v_fin_s;
            rr_r      <= rr_n_s;
            victim_r  <= victim_n_s;
            pf_v_r    <= pf_v_n_s;
            pf_addr_r <= pf_addr_n_s;
            busy_r    <= busy_n_s;
            for (int i = 0; i < streams_p; i++) begin
                tag_r[i]    <= tag_n_s[i];
                addr_r[i]   <= addr_n_s[i];
                stride_r[i] <= stride_n_s[i];
                rem_r[i]    <= rem_n_s[i];
`ifdef BP_BE_PF_PAGE_BOUND_EN
                page_r[i]   <= page_n_s[i];
`endif
            end
        end
    end

    assign pf_v_o    = pf_v_r;
    assign pf_addr_o = pf_addr_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_bp_be_stride_pf_sched.sv
// Scoreboard bench for bp_be_stride_pf_sched: expected prefetch addresses are queued
// at training time and popped on each accepted handshake.
module tb_bp_be_stride_pf_sched;

    localparam int VA = 39;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          train_v_i = 1'b0;
    logic [VA-1:0] train_pc_i = '0;
    logic [VA-1:0] train_addr_i = '0;
    logic [7:0]    train_stride_i = 8'd0;
    logic          flush_i = 1'b0;
    logic          demand_v_i = 1'b0;
    logic          pf_v_o;
    logic [VA-1:0] pf_addr_o;
    logic          pf_ready_i = 1'b1;
    logic          busy_o;

    int checks = 0;
    int failures = 0;
    logic [VA-1:0] sb[$];

    bp_be_stride_pf_sched dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .train_v_i(train_v_i), .train_pc_i(train_pc_i), .train_addr_i(train_addr_i),
        .train_stride_i(train_stride_i), .flush_i(flush_i), .demand_v_i(demand_v_i),
        .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o), .pf_ready_i(pf_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Scoreboard monitor: every accepted prefetch must match the oldest expectation.
    always @(negedge clk_i) begin
        if (reset_n_i && pf_v_o && pf_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h expected none", pf_addr_o);
            end else begin
                logic [VA-1:0] e;
                e = sb.pop_front();
                if (pf_addr_o !== e) begin
                    failures++;
                    $display("FAIL sb_addr got=%h expected=%h", pf_addr_o, e);
                end
            end
        end
    end

    task automatic apply_reset();
        reset_n_i = 1'b0;
        train_v_i = 1'b0; flush_i = 1'b0; demand_v_i = 1'b0; pf_ready_i = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    task automatic train_one(input logic [VA-1:0] pc, input logic [VA-1:0] addr,
                             input logic [7:0] stride);
        train_v_i = 1'b1; train_pc_i = pc; train_addr_i = addr; train_stride_i = stride;
        @(posedge clk_i); #1;
        train_v_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (pf_v_o !== 1'b0 || pf_addr_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b a=%h b=%b expected 0/0/0", pf_v_o, pf_addr_o, busy_o);
        end
    endtask

    task automatic test_single_train();
        logic [VA-1:0] exp_a;
        for (int n = 1; n <= 4; n++) sb.push_back(39'h8000 + 39'(64 * n));
        train_one(39'h100, 39'h8000, 8'd64);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk_i); #1;
            exp_a = 39'h8000 + 39'(64 * n);
            checks++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== exp_a) begin
                failures++;
                $display("FAIL single_seq n=%0d got v=%b a=%h expected v=1 a=%h", n, pf_v_o, pf_addr_o, exp_a);
            end
        end
        @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got v=%b busy=%b expected 0/0", pf_v_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        pf_ready_i = 1'b0;
        for (int n = 1; n <= 4; n++) sb.push_back(39'h8000 + 39'(64 * n));
        train_one(39'h100, 39'h8000, 8'd64);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            checks++;
            if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h8040) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%b a=%h expected v=1 a=0008040", c, pf_v_o, pf_addr_o);
            end
        end
        pf_ready_i = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bp_drain got left=%0d expected 0", sb.size());
        end
        repeat (2) @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle got v=%b busy=%b expected 0/0", pf_v_o, busy_o);
        end
    endtask

    task automatic test_demand();
        demand_v_i = 1'b1;
        for (int n = 1; n <= 4; n++) sb.push_back(39'h3000 + 39'(32 * n));
        train_one(39'h180, 39'h3000, 8'd32);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            checks++;
            if (pf_v_o !== 1'b0) begin
                failures++;
                $display("FAIL demand_block c=%0d got v=%b expected 0", c, pf_v_o);
            end
        end
        demand_v_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h3020) begin
            failures++;
            $display("FAIL demand_resume got v=%b a=%h expected v=1 a=0003020", pf_v_o, pf_addr_o);
        end
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL demand_drain got left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_refresh_and_zero();
        demand_v_i = 1'b1;
        train_one(39'h100, 39'h4000, 8'd64);
        train_one(39'h100, 39'h5000, 8'd32);
        train_one(39'h700, 39'h6000, 8'd0);
        for (int n = 1; n <= 4; n++) sb.push_back(39'h5000 + 39'(32 * n));
        demand_v_i = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        repeat (3) @(posedge clk_i); #1;
        checks++;
        if (sb.size() != 0 || pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL refresh_idle got left=%0d v=%b busy=%b expected 0/0/0", sb.size(), pf_v_o, busy_o);
        end
    endtask

    task automatic test_two_streams();
        apply_reset();
        demand_v_i = 1'b1;
        train_one(39'h200, 39'h1000, 8'd8);
        train_one(39'h300, 39'h2800, 8'hF0);
        for (int n = 1; n <= 4; n++) begin
            sb.push_back(39'h1000 + 39'(8 * n));
            sb.push_back(39'h2800 - 39'(16 * n));
        end
        demand_v_i = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL two_drain got left=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_overflow();
        int order [4] = '{5, 6, 3, 4};
        apply_reset();
        demand_v_i = 1'b1;
        for (int k = 1; k <= 6; k++) train_one(39'(k * 16), 39'(k * 39'h100000), 8'd16);
        for (int n = 1; n <= 4; n++)
            for (int e = 0; e < 4; e++) sb.push_back(39'(order[e] * 39'h100000) + 39'(16 * n));
        demand_v_i = 1'b0;
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk_i);
        repeat (2) @(posedge clk_i); #1;
        checks++;
        if (sb.size() != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL overflow_drain got left=%0d busy=%b expected 0/0", sb.size(), busy_o);
        end
    endtask

    task automatic test_flush();
        sb.push_back(39'h8040);
        train_one(39'h400, 39'h8000, 8'd64);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h8080) begin
            failures++;
            $display("FAIL flush_pre got v=%b a=%h expected v=1 a=0008080", pf_v_o, pf_addr_o);
        end
        pf_ready_i = 1'b0;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got v=%b busy=%b expected 0/0", pf_v_o, busy_o);
        end
        pf_ready_i = 1'b1;
        repeat (8) @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL flush_quiet got v=%b busy=%b left=%0d expected 0/0/0", pf_v_o, busy_o, sb.size());
        end
    endtask

    task automatic test_page();
`ifndef BP_BE_PF_PAGE_BOUND_EN
        for (int n = 1; n <= 4; n++) sb.push_back(39'h8FC0 + 39'(64 * n));
`endif
        train_one(39'h500, 39'h8FC0, 8'd64);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        repeat (4) @(posedge clk_i); #1;
        checks++;
        if (sb.size() != 0 || pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL page_result got left=%0d v=%b busy=%b expected 0/0/0", sb.size(), pf_v_o, busy_o);
        end
    endtask

    task automatic test_wrap();
`ifndef BP_BE_PF_PAGE_BOUND_EN
        for (int n = 1; n <= 4; n++) sb.push_back(39'h10 - 39'(32 * n));
        train_one(39'h580, 39'h10, 8'hE0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain got left=%0d expected 0", sb.size());
        end
`endif
    endtask

    task automatic test_async_reset();
        pf_ready_i = 1'b0;
        train_one(39'h600, 39'h100, 8'd4);
        @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b1 || pf_addr_o !== 39'h104) begin
            failures++;
            $display("FAIL arst_pre got v=%b a=%h expected v=1 a=0000104", pf_v_o, pf_addr_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL arst_drop got v=%b busy=%b expected 0/0", pf_v_o, busy_o);
        end
        sb.delete();
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        pf_ready_i = 1'b1;
        repeat (5) @(posedge clk_i); #1;
        checks++;
        if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL arst_after got v=%b busy=%b expected 0/0", pf_v_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_train();
        test_backpressure();
        test_demand();
        test_refresh_and_zero();
        test_two_streams();
        test_overflow();
        test_flush();
        test_page();
        test_wrap();
        test_async_reset();
        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
